// File: rtl/rr_priority_arbiter.sv
// N-input arbiter with fixed-priority or round-robin selection and a grant held until ack or withdrawal.
// Optional forced release of a stale grant when compiled with `define ARB_TIMEOUT_EN.
module rr_priority_arbiter #(
  parameter int N       = 8,
  parameter int MODE    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] out,
  output logic [N-1:0]         grant,
  output logic                 valid,
  output logic                 timeout
);

  localparam int W = $clog2(N);

  if (N < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("rr_priority_arbiter: N must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   winner_s;
  logic [W-1:0]   ptr_adv_s;
  logic [W:0]     scan_s;
  logic           found_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
`endif

  // Winner selection: highest set index, or first set bit at or after ptr (wrapping modulo N)
  always_comb begin
    winner_s = {W{1'b0}};
    found_s  = 1'b0;
    scan_s   = {(W+1){1'b0}};
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          winner_s = W'(i);
        end else begin
          winner_s = winner_s;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_s = {1'b0, ptr_q} + (W+1)'(k);
        if (scan_s >= (W+1)'(N)) begin
          scan_s = scan_s - (W+1)'(N);
        end else begin
          scan_s = scan_s;
        end
        if (!found_s && req[scan_s[W-1:0]]) begin
          winner_s = scan_s[W-1:0];
          found_s  = 1'b1;
        end else begin
          found_s  = found_s;
        end
      end
    end
  end

  // Pointer after a completed grant; explicit compare keeps the wrap right for non-power-of-2 N
  always_comb begin
    if (MODE == 1) begin
      ptr_adv_s = (out_q == W'(N - 1)) ? {W{1'b0}} : out_q + W'(1);
    end else begin
      ptr_adv_s = ptr_q;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req != {N{1'b0}}) begin
          state_d = GRANT;
          out_d   = winner_s;
          grant_d = {{(N-1){1'b0}}, 1'b1} << winner_s;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = {CW{1'b0}};
`endif
        end else begin
          out_d   = {W{1'b0}};
          grant_d = {N{1'b0}};
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d = IDLE;
          out_d   = {W{1'b0}};
          grant_d = {N{1'b0}};
          valid_d = 1'b0;
          ptr_d   = ptr_adv_s;
        end else if (!req[out_q]) begin
          state_d = IDLE;
          out_d   = {W{1'b0}};
          grant_d = {N{1'b0}};
          valid_d = 1'b0;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            out_d     = {W{1'b0}};
            grant_d   = {N{1'b0}};
            valid_d   = 1'b0;
            ptr_d     = ptr_adv_s;
            timeout_d = 1'b1;
          end else begin
            cnt_d     = cnt_q + CW'(1);
          end
`else
          state_d = GRANT;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = {W{1'b0}};
        grant_d = {N{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= {W{1'b0}};
      grant_q   <= {N{1'b0}};
      valid_q   <= 1'b0;
      ptr_q     <= {W{1'b0}};
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= {CW{1'b0}};
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign out   = out_q;
  assign grant = grant_q;
  assign valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench: three arbiter configurations (RR N=8, fixed N=8, RR N=5) against a queue-free integer reference model.
module tb_rr_priority_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack;

  logic [2:0] o0, o1, o2;
  logic [7:0] g0, g1;
  logic [4:0] g2;
  logic       v0, v1, v2, t0, t1, t2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(8), .MODE(1), .TIMEOUT(TO)) u_rr8 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .out(o0), .grant(g0), .valid(v0), .timeout(t0));

  rr_priority_arbiter #(.N(8), .MODE(0), .TIMEOUT(TO)) u_fp8 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .out(o1), .grant(g1), .valid(v1), .timeout(t1));

  rr_priority_arbiter #(.N(5), .MODE(1), .TIMEOUT(TO)) u_rr5 (
    .clk(clk), .rst(rst), .req(req[4:0]), .ack(ack),
    .out(o2), .grant(g2), .valid(v2), .timeout(t2));

  // reference model state per arbiter: 0 = rr8, 1 = fp8, 2 = rr5
  int m_n[3]    = '{8, 8, 5};
  int m_mode[3] = '{1, 0, 1};
  bit m_busy[3];
  int m_out[3];
  int m_ptr[3];
  int m_cnt[3];
  bit m_to[3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int d, input logic [7:0] r);
    if (m_mode[d] == 0) begin
      for (int i = m_n[d] - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < m_n[d]; k++) begin
        int j;
        j = (m_ptr[d] + k) % m_n[d];
        if (r[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [7:0] r_req, input logic r_ack);
    for (int d = 0; d < 3; d++) begin
      logic [7:0] rq;
      int p;
      rq = r_req & 8'((1 << m_n[d]) - 1);
      m_to[d] = 1'b0;
      if (r_rst) begin
        m_busy[d] = 1'b0; m_out[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      end else if (!m_busy[d]) begin
        p = pick(d, rq);
        if (p >= 0) begin
          m_busy[d] = 1'b1; m_out[d] = p; m_cnt[d] = 0;
        end
      end else if (r_ack) begin
        m_busy[d] = 1'b0;
        if (m_mode[d] == 1) m_ptr[d] = (m_out[d] + 1) % m_n[d];
      end else if (!rq[m_out[d]]) begin
        m_busy[d] = 1'b0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_cnt[d] == TO - 1) begin
          m_busy[d] = 1'b0;
          m_to[d]   = 1'b1;
          if (m_mode[d] == 1) m_ptr[d] = (m_out[d] + 1) % m_n[d];
        end else begin
          m_cnt[d]++;
        end
`endif
      end
    end
  endtask

  task automatic check_dut(input string name, input int d, input logic [2:0] o,
                           input logic [7:0] g, input logic v, input logic t);
    check_eq({name, "_valid"}, 32'(v), 32'(m_busy[d]));
    if (m_busy[d]) check_eq({name, "_out"}, 32'(o), 32'(m_out[d]));
    check_eq({name, "_grant"}, 32'(g), m_busy[d] ? (32'd1 << m_out[d]) : 32'd0);
    check_eq({name, "_timeout"}, 32'(t), 32'(m_to[d]));
  endtask

  task automatic cyc(input logic r, input logic [7:0] q, input logic a);
    rst = r; req = q; ack = a;
    @(posedge clk);
    model_step(r, q, a);
    #1;
    check_dut("rr8", 0, o0, g0, v0, t0);
    check_dut("fp8", 1, o1, g1, v1, t1);
    check_dut("rr5", 2, o2, {3'b000, g2}, v2, t2);
  endtask

  initial begin
    rst = 1'b1; req = 8'hFF; ack = 1'b0;

    // reset with all requests high
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    check_eq("rst_valid", 32'(v0), 32'd0);
    check_eq("rst_out", 32'(o0), 32'd0);
    check_eq("rst_grant", 32'(g0), 32'd0);
    check_eq("rst_timeout", 32'(t0), 32'd0);
    cyc(1'b0, 8'hFF, 1'b0);
    check_eq("rr_first", 32'(o0), 32'd0);

    // fixed priority: MSB wins, held until ack
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'b1001_0010, 1'b0);
    check_eq("fp_out", 32'(o1), 32'd7);
    check_eq("fp_grant", 32'(g1), 32'h80);
    repeat (3) cyc(1'b0, 8'hFF, 1'b0);
    check_eq("fp_hold", 32'(o1), 32'd7);
    cyc(1'b0, 8'hFF, 1'b1);
    check_eq("fp_gap", 32'(v1), 32'd0);
    cyc(1'b0, 8'hFF, 1'b0);
    check_eq("fp_again", 32'(o1), 32'd7);

    // round-robin fairness over all eight requesters
    cyc(1'b1, 8'hFF, 1'b0);
    for (int g = 0; g < 9; g++) begin
      cyc(1'b0, 8'hFF, 1'b1);
      check_eq("rr_seq", 32'(o0), 32'(g % 8));
      cyc(1'b0, 8'hFF, 1'b1);
      check_eq("rr_gap", 32'(v0), 32'd0);
    end

    // N=5 wrap: 0,4,0,4
    cyc(1'b1, 8'h00, 1'b0);
    for (int g = 0; g < 4; g++) begin
      cyc(1'b0, 8'h11, 1'b1);
      check_eq("rr5_seq", 32'(o2), (g % 2 == 1) ? 32'd4 : 32'd0);
      cyc(1'b0, 8'h11, 1'b1);
    end

    // withdrawal keeps ptr, reset mid-grant clears it
    cyc(1'b1, 8'h00, 1'b0);
    repeat (3) begin
      cyc(1'b0, 8'hFF, 1'b1);
      cyc(1'b0, 8'hFF, 1'b1);
    end
    cyc(1'b0, 8'hFF, 1'b0);
    check_eq("wd_grant3", 32'(o0), 32'd3);
    cyc(1'b0, 8'hF7, 1'b0);
    check_eq("wd_release", 32'(v0), 32'd0);
    cyc(1'b0, 8'hFF, 1'b0);
    check_eq("wd_regrant", 32'(o0), 32'd3);
    cyc(1'b1, 8'hFF, 1'b0);
    check_eq("midrst_valid", 32'(v0), 32'd0);
    cyc(1'b0, 8'hFF, 1'b0);
    check_eq("midrst_ptr", 32'(o0), 32'd0);

    // never-acked grant
    cyc(1'b1, 8'h00, 1'b0);
    repeat (5) cyc(1'b0, 8'h06, 1'b0);
`ifdef ARB_TIMEOUT_EN
    check_eq("to_pulse", 32'(t0), 32'd1);
    cyc(1'b0, 8'h06, 1'b0);
    check_eq("to_next", 32'(o0), 32'd2);
`else
    check_eq("to_none", 32'(t0), 32'd0);
    cyc(1'b0, 8'h06, 1'b0);
    check_eq("to_held", 32'(o0), 32'd1);
    check_eq("to_held_v", 32'(v0), 32'd1);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic       r, a;
      logic [7:0] q;
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      a = ($urandom_range(0, 3) == 0);
      cyc(r, q, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
